// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - register offsets and status bit positions for the MMIO I/O block
package io_pkg;

    localparam logic [7:0] IO_STATUS   = 8'h00;
    localparam logic [7:0] IO_RX_DATA  = 8'h04;
    localparam logic [7:0] IO_TX_DATA  = 8'h08;
    localparam logic [7:0] IO_CYC_CNT  = 8'h10;
    localparam logic [7:0] IO_INST_CNT = 8'h14;
    localparam logic [7:0] IO_CNT_RST  = 8'h18;

    localparam int STAT_TX_FREE     = 0;
    localparam int STAT_RX_NONEMPTY = 1;

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - count-based synchronous FIFO with combinational head output
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - MMIO decode for UART RX FIFO, TX slot and cycle/instruction counters
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        inst_retired,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    logic                 rd_req;
    logic                 wr_req;
    logic                 rx_pop;
    logic                 rx_full;
    logic                 rx_empty;
    logic [7:0]           rx_head;
    logic                 tx_load;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] inst_cnt;
    logic [31:0]          rd_next;
    logic                 unused_wdata;

    assign unused_wdata = ^io_wdata[31:8];

    assign rd_req  = io_en & ~io_we;
    assign wr_req  = io_en & io_we;
    assign rx_pop  = rd_req & (io_addr == IO_RX_DATA) & ~rx_empty;
    // Free-ness is the pre-edge slot state, so a store racing the handshake is dropped.
    assign tx_load = wr_req & (io_addr == IO_TX_DATA) & ~uart_tx_valid;
    assign cnt_clr = wr_req & (io_addr == IO_CNT_RST);

    assign uart_rx_ready = ~rx_full;

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid),
        .din   (uart_rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (tx_load) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= io_wdata[7:0];
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
            inst_cnt <= inst_cnt + {{(CNT_WIDTH-1){1'b0}}, inst_retired};
        end
    end

    always_comb begin
        rd_next = 32'h0;
        case (io_addr)
            IO_STATUS: begin
                rd_next[STAT_TX_FREE]     = ~uart_tx_valid;
                rd_next[STAT_RX_NONEMPTY] = ~rx_empty;
            end
            IO_RX_DATA:  rd_next = rx_empty ? 32'h0 : {24'h0, rx_head};
            IO_CYC_CNT:  rd_next = 32'(cyc_cnt);
            IO_INST_CNT: rd_next = 32'(inst_cnt);
            default:     rd_next = 32'h0;
        endcase
    end

    // Load data is held until the next load, matching BIOS/DMEM read timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdata <= 32'h0;
        end else if (rd_req) begin
            io_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - self-checking bench for mmio_io_ctrl
module tb_mmio_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_en;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .RX_FIFO_DEPTH (8),
        .CNT_WIDTH     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .inst_retired  (inst_retired),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge: issue a load, then compare the registered result one edge later.
    task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
        sb_entry_t e;
        io_en   = 1'b1;
        io_we   = 1'b0;
        io_addr = a;
        sb_q.push_back('{exp: exp, name: nm});
        @(negedge clk);
        io_en = 1'b0;
        if (sb_q.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, io_rdata, e.exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        io_en    = 1'b1;
        io_we    = 1'b1;
        io_addr  = a;
        io_wdata = d;
        @(negedge clk);
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    rd_vec_t rst_tab[7];
    rd_vec_t rx_tab[7];

    initial begin
        rst_tab[0] = '{8'h00, 32'h1, "rst status"};
        rst_tab[1] = '{8'h04, 32'h0, "rst rx empty read"};
        rst_tab[2] = '{8'h08, 32'h0, "read of tx reg"};
        rst_tab[3] = '{8'h0C, 32'h0, "unmapped 0x0c"};
        rst_tab[4] = '{8'h18, 32'h0, "read of cnt_rst"};
        rst_tab[5] = '{8'hFF, 32'h0, "unmapped 0xff"};
        rst_tab[6] = '{8'h01, 32'h0, "unaligned 0x01"};

        rx_tab[0] = '{8'h04, 32'h41, "rx pop 0"};
        rx_tab[1] = '{8'h04, 32'h42, "rx pop 1"};
        rx_tab[2] = '{8'h00, 32'h3,  "status rx nonempty"};
        rx_tab[3] = '{8'h04, 32'h43, "rx pop 2"};
        rx_tab[4] = '{8'h00, 32'h1,  "status rx drained"};
        rx_tab[5] = '{8'h04, 32'h0,  "rx pop empty"};
        rx_tab[6] = '{8'h00, 32'h1,  "status still empty"};

        rst = 1'b1;
        io_en = 1'b0; io_we = 1'b0; io_addr = 8'h0; io_wdata = 32'h0;
        inst_retired = 1'b0;
        uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst io_rdata", io_rdata, 32'h0);
        chk("rst rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        chk("rst tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("rst tx_data", {24'h0, uart_tx_data}, 32'h0);
        rst = 1'b0;

        // Test 1 plus decode of unmapped addresses
        for (int i = 0; i < 7; i++) do_read(rst_tab[i].addr, rst_tab[i].exp, rst_tab[i].name);

        // Test 2: three bytes in, four pops out
        rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
        for (int i = 0; i < 7; i++) do_read(rx_tab[i].addr, rx_tab[i].exp, rx_tab[i].name);

        // Test 3: fill, stall, pop frees a slot for the ninth byte
        for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
        chk("rx full ready", {31'h0, uart_rx_ready}, 32'h0);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h18;
        @(negedge clk);
        chk("rx stall ready", {31'h0, uart_rx_ready}, 32'h0);
        do_read(8'h04, 32'h10, "pop during stall");
        chk("rx ready after pop", {31'h0, uart_rx_ready}, 32'h1);
        @(negedge clk);
        uart_rx_valid = 1'b0;
        chk("rx full again", {31'h0, uart_rx_ready}, 32'h0);
        for (int i = 1; i <= 8; i++) do_read(8'h04, 32'h10 + i, "rx order after wrap");
        do_read(8'h04, 32'h0, "rx empty after wrap");

        // Test 4: tx slot occupancy and dropped stores
        uart_tx_ready = 1'b0;
        do_write(8'h08, 32'hABCD_EF55);
        chk("tx valid set", {31'h0, uart_tx_valid}, 32'h1);
        chk("tx data", {24'h0, uart_tx_data}, 32'h55);
        do_read(8'h00, 32'h0, "status tx busy");
        do_write(8'h08, 32'h66);
        chk("tx second dropped", {24'h0, uart_tx_data}, 32'h55);
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        chk("tx valid cleared", {31'h0, uart_tx_valid}, 32'h0);
        do_read(8'h00, 32'h1, "status tx free");
        do_write(8'h08, 32'h77);
        uart_tx_ready = 1'b1;
        do_write(8'h08, 32'h88);
        uart_tx_ready = 1'b0;
        chk("tx handshake-cycle store valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("tx handshake-cycle store data", {24'h0, uart_tx_data}, 32'h77);

        // Test 5: counters, clear beats a same-cycle retire
        inst_retired = 1'b1;
        do_write(8'h18, 32'hFFFF_FFFF);
        for (int i = 0; i < 100; i++) begin
            inst_retired = logic'(i % 2);
            @(negedge clk);
        end
        inst_retired = 1'b0;
        do_read(8'h10, 32'd100, "cycle count");
        do_read(8'h14, 32'd50, "inst count");
        do_write(8'h18, 32'h0);
        do_read(8'h10, 32'd0, "cycle after clear");
        do_read(8'h14, 32'd0, "inst after clear");
        do_read(8'h10, 32'd2, "cycle keeps running");

        // Test 6: async reset with data buffered and tx busy
        rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3);
        do_write(8'h08, 32'h99);
        do_read(8'h00, 32'h2, "status before reset");
        #2 rst = 1'b1;
        #1;
        chk("async rst io_rdata", io_rdata, 32'h0);
        chk("async rst rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        chk("async rst tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("async rst tx_data", {24'h0, uart_tx_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_read(8'h10, 32'h0, "cycle after reset");
        do_read(8'h14, 32'h0, "inst after reset");
        do_read(8'h04, 32'h0, "rx flushed by reset");
        do_read(8'h00, 32'h1, "status after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
